id_decode_hazard: RTL and testbench
===================================

Name: id_decode_hazard

Overview:
- Instruction decode stage that consumes the IF stage's PC/IR pipeline register and returns the IF control signals IsStall, IsBranch and BranchAddr.
- Decodes IR and reads the register file.
- Detects load-use and branch-operand hazards, resolves branches and jumps, and squashes the wrong-path fetch.
- Owns the ID/EX pipeline register that feeds EX.

Parameters:
- WIDTH, 32, datapath width; PC is WIDTH-2 bits (byte address).
- RAW, 5, register address width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- PC  in  WIDTH-2  IF PC output; always equals (address of IR)+4.
- IR  in  WIDTH  IF instruction register.
- IsStall  out  1  to IF; combinational; holds IF PC/IR.
- IsBranch  out  1  to IF; combinational; redirect.
- BranchAddr  out  WIDTH-2  to IF; combinational redirect target.
- rs_addr  out  RAW  regfile read port A = IR[25:21].
- rt_addr  out  RAW  regfile read port B = IR[20:16].
- rs_data  in  WIDTH  regfile port A data; combinational, write-first bypass inside regfile.
- rt_data  in  WIDTH  regfile port B data.
- mem_wr_en  in  1  instruction in MEM writes a register.
- mem_rd  in  RAW  MEM destination register.
- ex_valid  out  1  ID/EX register: valid instruction.
- ex_pc  out  WIDTH-2  address of the instruction (PC-4).
- ex_op  out  6  opcode.
- ex_funct  out  6  IR[5:0].
- ex_rd  out  RAW  destination register.
- ex_wr_en  out  1  writes a register.
- ex_is_load  out  1  LW.
- ex_is_store  out  1  SW.
- ex_imm  out  WIDTH  sign-extended IR[15:0].
- ex_rs_data  out  WIDTH  operand A.
- ex_rt_data  out  WIDTH  operand B.
- illegal_op  out  1  registered one-cycle pulse on an undefined opcode.

Behaviour:
- Encoding is op=IR[31:26]: 0x00 R-type (dest rd=IR[15:11]), 0x08 ADDI (dest rt), 0x23 LW (dest rt), 0x2B SW, 0x04 BEQ, 0x05 BNE, 0x02 J. Any other opcode is illegal: decoded as a bubble and illegal_op=1 next cycle.
- Writes to r0 never set ex_wr_en; r0 is never a hazard source.
- State:
  - valid_q: IR is meaningful. Reset 0; set on the first edge after reset.
  - squash_q: discard current IR. Set on the edge where IsBranch=1; cleared on the next non-stalled edge.
  - ID/EX register: all ex_* and illegal_op reset to 0.
- live = valid_q & ~squash_q.
- reads_rs / reads_rt follow the opcode:
  - R-type, BEQ, BNE read rs and rt.
  - ADDI and LW read rs.
  - SW reads rs and rt.
  - J reads neither.
- Hazard terms:
  - lu = live & ex_valid & ex_is_load & ex_wr_en & ex_rd matches a read register.
  - bh = live & (BEQ|BNE) & one of:
    - ex_valid & ex_wr_en & ex_rd matches rs/rt;
    - mem_wr_en & mem_rd≠0 & mem_rd matches rs/rt.
- IsStall = lu | bh.
- On a stall edge: ID/EX loads a bubble (ex_valid=0, ex_wr_en=0, ex_is_load=0, ex_is_store=0); valid_q and squash_q hold. IF holds PC/IR, so the same IR is re-decoded.
- taken is true when live & ~IsStall and the instruction is one of:
  - J;
  - BEQ with rs_data==rt_data;
  - BNE with rs_data≠rt_data.
- IsBranch = taken.
- BranchAddr:
  - BEQ/BNE: PC + (sext(IR[15:0])<<2), truncated to WIDTH-2 bits with wrap-around.
  - J: zero-extend(IR[25:0]<<2) into WIDTH-2 bits.
  - Otherwise 0.
- Taken branch edge: ID/EX receives the branch itself (ex_valid=1, ex_wr_en=0). squash_q←1, because IF latches the sequential wrong-path word.
- Squashed cycle: ID/EX bubble; no stall or branch is evaluated; squash_q←0.
- Normal edge: ID/EX loads the decoded fields, ex_pc=PC-4, ex_rs_data=rs_data, ex_rt_data=rt_data, ex_valid=1.
- Priority (high to low): rst, ~live (bubble), IsStall, taken, normal.
- Branch-decode latency:
  - Redirect is 0 cycles; IsBranch is asserted in the cycle the branch sits in IR.
  - Penalty is exactly one squashed slot.
- Load-use penalty is exactly one bubble; the stall deasserts once the load moves to MEM (ex_valid then holds the bubble).
- Branch after an ALU write: 2 stall cycles if the write is in EX, 1 if it is in MEM.
- rst asserted mid-stall or mid-squash clears all state immediately; outputs go to 0 without waiting for clk.

Test Plan:
- Reset release, then IR=ADDI r1,r0,5 at PC=4 → cycle 1 bubble (valid_q=0). Next edge: ex_valid=1, ex_rd=1, ex_imm=5, ex_pc=0; IsStall=0.
- LW r2,0(r1) then ADD r3,r2,r2 → IsStall=1 for one cycle, one bubble in ID/EX, then ADD issues with ex_rd=3.
- BEQ r4,r5,+3 at address 0x10 (PC=0x14), rs_data=rt_data=7 → IsBranch=1, BranchAddr=0x20. The next cycle is squashed (ex_valid=0); the instruction at 0x20 then issues.
- BNE with rs_data=rt_data=9 → IsBranch=0, no squash, sequential flow.
- J with IR[25:0]=0x40 → BranchAddr=0x100, one squashed slot.
- ADD r6,.. immediately followed by BEQ r6,r0 → 2 stall cycles (EX, then MEM hazard), then branch resolves.
- Assert rst during the load-use stall → all ex_*, IsStall and IsBranch are 0 asynchronously. After release, first-cycle invalid behaviour repeats.

Source files
------------

// File: rtl/id_decode_hazard.sv
`default_nettype none
// ============================================================================
// Module   : id_decode_hazard
// Purpose  : Instruction decode stage. Decodes IR, detects load-use and
//            branch-operand hazards, resolves branches/jumps in ID, squashes
//            the wrong-path fetch, and owns the ID/EX pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module id_decode_hazard #(
    parameter int WIDTH = 32,
    parameter int RAW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-3:0] PC,
    input  logic [WIDTH-1:0] IR,
    output logic             IsStall,
    output logic             IsBranch,
    output logic [WIDTH-3:0] BranchAddr,
    output logic [RAW-1:0]   rs_addr,
    output logic [RAW-1:0]   rt_addr,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mem_wr_en,
    input  logic [RAW-1:0]   mem_rd,
    output logic             ex_valid,
    output logic [WIDTH-3:0] ex_pc,
    output logic [5:0]       ex_op,
    output logic [5:0]       ex_funct,
    output logic [RAW-1:0]   ex_rd,
    output logic             ex_wr_en,
    output logic             ex_is_load,
    output logic             ex_is_store,
    output logic [WIDTH-1:0] ex_imm,
    output logic [WIDTH-1:0] ex_rs_data,
    output logic [WIDTH-1:0] ex_rt_data,
    output logic             illegal_op
);

    localparam int PW = WIDTH - 2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic             valid_q, valid_d;
    logic             squash_q, squash_d;
    logic             ex_valid_q, ex_valid_d;
    logic [PW-1:0]    ex_pc_q, ex_pc_d;
    logic [5:0]       ex_op_q, ex_op_d;
    logic [5:0]       ex_funct_q, ex_funct_d;
    logic [RAW-1:0]   ex_rd_q, ex_rd_d;
    logic             ex_wr_en_q, ex_wr_en_d;
    logic             ex_is_load_q, ex_is_load_d;
    logic             ex_is_store_q, ex_is_store_d;
    logic [WIDTH-1:0] ex_imm_q, ex_imm_d;
    logic [WIDTH-1:0] ex_rs_data_q, ex_rs_data_d;
    logic [WIDTH-1:0] ex_rt_data_q, ex_rt_data_d;
    logic             illegal_op_q, illegal_op_d;

    logic [5:0]       w_op;
    logic [RAW-1:0]   w_rd_field;
    logic             w_is_r, w_is_j, w_is_beq, w_is_bne, w_is_addi, w_is_lw, w_is_sw;
    logic             w_is_illegal, w_is_cond;
    logic             w_reads_rs, w_reads_rt;
    logic [RAW-1:0]   w_dest;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_imm;
    logic             w_live, w_lu, w_bh, w_stall, w_taken, w_load;
    logic             w_ex_hit, w_mem_hit;
    logic [PW-1:0]    w_br_off;

    // ---------------- decode ----------------
    assign w_op       = IR[31:26];
    assign rs_addr    = RAW'(IR[25:21]);
    assign rt_addr    = RAW'(IR[20:16]);
    assign w_rd_field = RAW'(IR[15:11]);
    assign w_imm      = {{(WIDTH-16){IR[15]}}, IR[15:0]};

    assign w_is_r    = (w_op == OP_RTYPE);
    assign w_is_j    = (w_op == OP_J);
    assign w_is_beq  = (w_op == OP_BEQ);
    assign w_is_bne  = (w_op == OP_BNE);
    assign w_is_addi = (w_op == OP_ADDI);
    assign w_is_lw   = (w_op == OP_LW);
    assign w_is_sw   = (w_op == OP_SW);
    assign w_is_cond = w_is_beq | w_is_bne;
    assign w_is_illegal = ~(w_is_r | w_is_j | w_is_cond | w_is_addi | w_is_lw | w_is_sw);

    assign w_reads_rs = w_is_r | w_is_cond | w_is_addi | w_is_lw | w_is_sw;
    assign w_reads_rt = w_is_r | w_is_cond | w_is_sw;

    assign w_dest  = w_is_r ? w_rd_field : ((w_is_addi | w_is_lw) ? rt_addr : '0);
    assign w_wr_en = (w_is_r | w_is_addi | w_is_lw) & (w_dest != '0);

    // ---------------- hazards and branch resolution ----------------
    // ex_wr_en is never set for r0, so the EX comparisons exclude r0 implicitly.
    assign w_live = valid_q & ~squash_q;

    assign w_lu = w_live & ex_valid_q & ex_is_load_q & ex_wr_en_q &
                  ((w_reads_rs & (ex_rd_q == rs_addr)) |
                   (w_reads_rt & (ex_rd_q == rt_addr)));

    assign w_ex_hit  = ex_valid_q & ex_wr_en_q &
                       ((ex_rd_q == rs_addr) | (ex_rd_q == rt_addr));
    assign w_mem_hit = mem_wr_en & (mem_rd != '0) &
                       ((mem_rd == rs_addr) | (mem_rd == rt_addr));
    assign w_bh      = w_live & w_is_cond & (w_ex_hit | w_mem_hit);

    assign w_stall = w_lu | w_bh;
    assign w_taken = w_live & ~w_stall &
                     (w_is_j |
                      (w_is_beq & (rs_data == rt_data)) |
                      (w_is_bne & (rs_data != rt_data)));

    assign w_br_off = {w_imm[PW-3:0], 2'b00};

    always_comb begin
        BranchAddr = '0;
        if (w_is_cond) begin
            BranchAddr = PC + w_br_off;
        end else if (w_is_j) begin
            BranchAddr = {{(PW-28){1'b0}}, IR[25:0], 2'b00};
        end
    end

    assign IsStall  = w_stall;
    assign IsBranch = w_taken;

    // ---------------- ID/EX next state ----------------
    // A taken branch still flows to EX; illegal opcodes become bubbles.
    assign w_load = w_live & ~w_stall & ~w_is_illegal;

    always_comb begin
        valid_d       = 1'b1;
        squash_d      = w_taken;
        ex_valid_d    = w_load;
        ex_wr_en_d    = w_load & w_wr_en;
        ex_is_load_d  = w_load & w_is_lw;
        ex_is_store_d = w_load & w_is_sw;
        illegal_op_d  = w_live & ~w_stall & w_is_illegal;
        ex_pc_d       = ex_pc_q;
        ex_op_d       = ex_op_q;
        ex_funct_d    = ex_funct_q;
        ex_rd_d       = ex_rd_q;
        ex_imm_d      = ex_imm_q;
        ex_rs_data_d  = ex_rs_data_q;
        ex_rt_data_d  = ex_rt_data_q;
        if (w_load) begin
            ex_pc_d      = PC - PW'(4);
            ex_op_d      = w_op;
            ex_funct_d   = IR[5:0];
            ex_rd_d      = w_dest;
            ex_imm_d     = w_imm;
            ex_rs_data_d = rs_data;
            ex_rt_data_d = rt_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= 1'b0;
            squash_q      <= 1'b0;
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_op_q       <= '0;
            ex_funct_q    <= '0;
            ex_rd_q       <= '0;
            ex_wr_en_q    <= 1'b0;
            ex_is_load_q  <= 1'b0;
            ex_is_store_q <= 1'b0;
            ex_imm_q      <= '0;
            ex_rs_data_q  <= '0;
            ex_rt_data_q  <= '0;
            illegal_op_q  <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            squash_q      <= squash_d;
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_op_q       <= ex_op_d;
            ex_funct_q    <= ex_funct_d;
            ex_rd_q       <= ex_rd_d;
            ex_wr_en_q    <= ex_wr_en_d;
            ex_is_load_q  <= ex_is_load_d;
            ex_is_store_q <= ex_is_store_d;
            ex_imm_q      <= ex_imm_d;
            ex_rs_data_q  <= ex_rs_data_d;
            ex_rt_data_q  <= ex_rt_data_d;
            illegal_op_q  <= illegal_op_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_pc       = ex_pc_q;
    assign ex_op       = ex_op_q;
    assign ex_funct    = ex_funct_q;
    assign ex_rd       = ex_rd_q;
    assign ex_wr_en    = ex_wr_en_q;
    assign ex_is_load  = ex_is_load_q;
    assign ex_is_store = ex_is_store_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rs_data  = ex_rs_data_q;
    assign ex_rt_data  = ex_rt_data_q;
    assign illegal_op  = illegal_op_q;

endmodule
`default_nettype wire

// File: tb/tb_id_decode_hazard.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_decode_hazard
// Purpose  : Directed self-checking bench for id_decode_hazard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_decode_hazard;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] PC;
    logic [31:0] IR;
    logic        IsStall, IsBranch;
    logic [29:0] BranchAddr;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic        mem_wr_en;
    logic [4:0]  mem_rd;
    logic        ex_valid;
    logic [29:0] ex_pc;
    logic [5:0]  ex_op, ex_funct;
    logic [4:0]  ex_rd;
    logic        ex_wr_en, ex_is_load, ex_is_store;
    logic [31:0] ex_imm, ex_rs_data, ex_rt_data;
    logic        illegal_op;

    int n_checks = 0;
    int n_fail   = 0;

    id_decode_hazard #(.WIDTH(32), .RAW(5)) dut (
        .clk(clk), .rst(rst), .PC(PC), .IR(IR),
        .IsStall(IsStall), .IsBranch(IsBranch), .BranchAddr(BranchAddr),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .mem_wr_en(mem_wr_en), .mem_rd(mem_rd),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op(ex_op), .ex_funct(ex_funct),
        .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
        .ex_is_store(ex_is_store), .ex_imm(ex_imm), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; PC = '0; IR = '0; rs_data = '0; rt_data = '0;
        mem_wr_en = 1'b0; mem_rd = '0;
        #2;
        n_checks++;
        if ({ex_valid, ex_wr_en, ex_is_load, ex_is_store, illegal_op, IsStall, IsBranch} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl got %b exp 0", {ex_valid, ex_wr_en, ex_is_load, ex_is_store, illegal_op, IsStall, IsBranch});
        end
        n_checks++;
        if ({ex_pc, ex_rd, ex_imm, ex_rs_data, ex_rt_data} !== '0) begin
            n_fail++; $display("FAIL reset_data got nonzero exp 0");
        end
        step();
        rst = 1'b0;
        IR = i_type(6'h08, 5'd0, 5'd1, 16'd5); PC = 30'h4;
        #1;
        n_checks++;
        if (IsStall !== 1'b0) begin n_fail++; $display("FAIL first_stall got %b exp 0", IsStall); end
        step();
        n_checks++;
        if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL first_bubble got %b exp 0", ex_valid); end
        step();
        n_checks++;
        if ({ex_valid, ex_wr_en, ex_rd, ex_imm, ex_pc} !== {1'b1, 1'b1, 5'd1, 32'd5, 30'h0}) begin
            n_fail++; $display("FAIL addi_issue got v=%b w=%b rd=%0d imm=%0h pc=%0h exp v=1 w=1 rd=1 imm=5 pc=0",
                               ex_valid, ex_wr_en, ex_rd, ex_imm, ex_pc);
        end
    endtask

    task automatic test_load_use();
        IR = i_type(6'h23, 5'd1, 5'd2, 16'd0); PC = 30'h8;
        #1;
        n_checks++;
        if (IsStall !== 1'b0) begin n_fail++; $display("FAIL lw_nostall got %b exp 0", IsStall); end
        step();
        n_checks++;
        if ({ex_is_load, ex_rd, ex_wr_en} !== {1'b1, 5'd2, 1'b1}) begin
            n_fail++; $display("FAIL lw_issue got ld=%b rd=%0d w=%b exp 1 2 1", ex_is_load, ex_rd, ex_wr_en);
        end
        IR = r_type(5'd2, 5'd2, 5'd3, 6'h20); PC = 30'hC;
        #1;
        n_checks++;
        if (IsStall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b exp 1", IsStall); end
        step();
        n_checks++;
        if ({ex_valid, IsStall} !== 2'b00) begin
            n_fail++; $display("FAIL lu_bubble got v=%b stall=%b exp 0 0", ex_valid, IsStall);
        end
        step();
        n_checks++;
        if ({ex_valid, ex_rd, ex_pc, ex_funct} !== {1'b1, 5'd3, 30'h8, 6'h20}) begin
            n_fail++; $display("FAIL add_issue got v=%b rd=%0d pc=%0h fn=%0h exp 1 3 8 20", ex_valid, ex_rd, ex_pc, ex_funct);
        end
    endtask

    task automatic test_branch_taken();
        IR = i_type(6'h04, 5'd4, 5'd5, 16'd3); PC = 30'h14;
        rs_data = 32'd7; rt_data = 32'd7;
        #1;
        n_checks++;
        if ({IsStall, IsBranch, BranchAddr} !== {1'b0, 1'b1, 30'h20}) begin
            n_fail++; $display("FAIL beq_taken got st=%b br=%b addr=%0h exp 0 1 20", IsStall, IsBranch, BranchAddr);
        end
        step();
        n_checks++;
        if ({ex_valid, ex_wr_en, ex_pc, ex_op} !== {1'b1, 1'b0, 30'h10, 6'h04}) begin
            n_fail++; $display("FAIL beq_issue got v=%b w=%b pc=%0h op=%0h exp 1 0 10 4", ex_valid, ex_wr_en, ex_pc, ex_op);
        end
        // Wrong-path word is itself a jump; it must be ignored.
        IR = {6'h02, 26'h40}; PC = 30'h18;
        #1;
        n_checks++;
        if ({IsBranch, IsStall} !== 2'b00) begin
            n_fail++; $display("FAIL squash_nobranch got br=%b st=%b exp 0 0", IsBranch, IsStall);
        end
        step();
        n_checks++;
        if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL squash_bubble got %b exp 0", ex_valid); end
        IR = i_type(6'h08, 5'd0, 5'd8, 16'd9); PC = 30'h24;
        step();
        n_checks++;
        if ({ex_valid, ex_pc, ex_rd} !== {1'b1, 30'h20, 5'd8}) begin
            n_fail++; $display("FAIL target_issue got v=%b pc=%0h rd=%0d exp 1 20 8", ex_valid, ex_pc, ex_rd);
        end
    endtask

    task automatic test_branch_not_taken();
        IR = i_type(6'h05, 5'd4, 5'd5, 16'd3); PC = 30'h28;
        rs_data = 32'd9; rt_data = 32'd9;
        #1;
        n_checks++;
        if ({IsStall, IsBranch} !== 2'b00) begin
            n_fail++; $display("FAIL bne_nt got st=%b br=%b exp 0 0", IsStall, IsBranch);
        end
        step();
        IR = i_type(6'h08, 5'd0, 5'd9, 16'd2); PC = 30'h2C;
        step();
        n_checks++;
        if ({ex_valid, ex_rd, ex_pc} !== {1'b1, 5'd9, 30'h28}) begin
            n_fail++; $display("FAIL bne_seq got v=%b rd=%0d pc=%0h exp 1 9 28", ex_valid, ex_rd, ex_pc);
        end
    endtask

    task automatic test_jump();
        IR = {6'h02, 26'h40}; PC = 30'h30;
        #1;
        n_checks++;
        if ({IsBranch, BranchAddr} !== {1'b1, 30'h100}) begin
            n_fail++; $display("FAIL jump got br=%b addr=%0h exp 1 100", IsBranch, BranchAddr);
        end
        step();
        IR = i_type(6'h08, 5'd0, 5'd11, 16'd1); PC = 30'h34;
        step();
        n_checks++;
        if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL jump_squash got %b exp 0", ex_valid); end
        IR = i_type(6'h08, 5'd0, 5'd10, 16'd1); PC = 30'h104;
        step();
        n_checks++;
        if ({ex_valid, ex_pc, ex_rd} !== {1'b1, 30'h100, 5'd10}) begin
            n_fail++; $display("FAIL jump_target got v=%b pc=%0h rd=%0d exp 1 100 10", ex_valid, ex_pc, ex_rd);
        end
    endtask

    task automatic test_branch_hazard();
        IR = r_type(5'd1, 5'd2, 5'd6, 6'h20); PC = 30'h108;
        step();
        IR = i_type(6'h04, 5'd6, 5'd0, 16'd1); PC = 30'h10C;
        rs_data = 32'd0; rt_data = 32'd0;
        #1;
        n_checks++;
        if ({IsStall, IsBranch} !== 2'b10) begin
            n_fail++; $display("FAIL bh_ex got st=%b br=%b exp 1 0", IsStall, IsBranch);
        end
        step();
        mem_wr_en = 1'b1; mem_rd = 5'd6;
        #1;
        n_checks++;
        if ({ex_valid, IsStall, IsBranch} !== 3'b010) begin
            n_fail++; $display("FAIL bh_mem got v=%b st=%b br=%b exp 0 1 0", ex_valid, IsStall, IsBranch);
        end
        step();
        // MEM writing r0 must not count as a hazard even though rt=r0.
        mem_wr_en = 1'b1; mem_rd = 5'd0;
        #1;
        n_checks++;
        if ({ex_valid, IsStall, IsBranch, BranchAddr} !== {1'b0, 1'b0, 1'b1, 30'h110}) begin
            n_fail++; $display("FAIL bh_resolve got v=%b st=%b br=%b addr=%0h exp 0 0 1 110", ex_valid, IsStall, IsBranch, BranchAddr);
        end
        step();
        mem_wr_en = 1'b0;
        n_checks++;
        if ({ex_valid, ex_op} !== {1'b1, 6'h04}) begin
            n_fail++; $display("FAIL bh_issue got v=%b op=%0h exp 1 4", ex_valid, ex_op);
        end
        IR = r_type(5'd1, 5'd1, 5'd7, 6'h20); PC = 30'h110;
        step();
    endtask

    task automatic test_illegal_and_r0();
        IR = {6'h3F, 26'h0}; PC = 30'h114;
        step();
        n_checks++;
        if ({illegal_op, ex_valid} !== 2'b10) begin
            n_fail++; $display("FAIL illegal got ill=%b v=%b exp 1 0", illegal_op, ex_valid);
        end
        IR = i_type(6'h08, 5'd0, 5'd0, 16'hFFFF); PC = 30'h118;
        step();
        n_checks++;
        if ({illegal_op, ex_valid, ex_wr_en, ex_imm} !== {1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF}) begin
            n_fail++; $display("FAIL r0_write got ill=%b v=%b w=%b imm=%0h exp 0 1 0 ffffffff", illegal_op, ex_valid, ex_wr_en, ex_imm);
        end
        IR = i_type(6'h2B, 5'd1, 5'd3, 16'd8); PC = 30'h11C;
        rs_data = 32'hA5; rt_data = 32'h5A;
        step();
        n_checks++;
        if ({ex_is_store, ex_wr_en, ex_rs_data, ex_rt_data} !== {1'b1, 1'b0, 32'hA5, 32'h5A}) begin
            n_fail++; $display("FAIL sw_issue got st=%b w=%b a=%0h b=%0h exp 1 0 a5 5a", ex_is_store, ex_wr_en, ex_rs_data, ex_rt_data);
        end
    endtask

    task automatic test_reset_mid_stall();
        IR = i_type(6'h23, 5'd1, 5'd2, 16'd0); PC = 30'h120;
        step();
        IR = r_type(5'd2, 5'd2, 5'd3, 6'h20); PC = 30'h124;
        #1;
        n_checks++;
        if (IsStall !== 1'b1) begin n_fail++; $display("FAIL pre_rst_stall got %b exp 1", IsStall); end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ex_valid, ex_wr_en, ex_is_load, ex_rd, ex_pc, IsStall, IsBranch} !== '0) begin
            n_fail++; $display("FAIL async_rst got v=%b w=%b ld=%b rd=%0d pc=%0h st=%b br=%b exp all 0",
                               ex_valid, ex_wr_en, ex_is_load, ex_rd, ex_pc, IsStall, IsBranch);
        end
        step();
        rst = 1'b0;
        IR = i_type(6'h08, 5'd0, 5'd1, 16'd5); PC = 30'h4;
        step();
        n_checks++;
        if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_bubble got %b exp 0", ex_valid); end
        step();
        n_checks++;
        if ({ex_valid, ex_rd, ex_pc} !== {1'b1, 5'd1, 30'h0}) begin
            n_fail++; $display("FAIL post_rst_issue got v=%b rd=%0d pc=%0h exp 1 1 0", ex_valid, ex_rd, ex_pc);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_taken();
        test_branch_not_taken();
        test_jump();
        test_branch_hazard();
        test_illegal_and_r0();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
